// File: rtl/motion_seq.sv
// Line-motion sequencer: loads a cascaded 12-bit counter chain from a moving
// position register and reports terminal count once per line.
module motion_seq #(
  parameter logic [11:0] POS_INIT = 12'hF00
) (
  input  logic        clk,
  input  logic        _clr,
  input  logic        start,
  input  logic        vstart,
  input  logic [3:0]  vel,
  input  logic        freeze,
  input  logic        carry_in,
  output logic        _load,
  output logic        en_p,
  output logic        en_t,
  output logic [11:0] preset,
  output logic        hit,
  output logic        busy
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned VEL_W = 4;

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   vel_ext;
  logic               load_nxt, en_nxt, hit_nxt, busy_nxt;

  assign vel_ext = {{(POS_W-VEL_W){vel[VEL_W-1]}}, vel};
  assign preset  = pos;

  // Position moves once per frame unless frozen; wraps modulo 4096.
  always_ff @(posedge clk or negedge _clr) begin
    if (!_clr) begin
      pos <= POS_INIT;
    end else if (vstart && !freeze) begin
      pos <= pos + vel_ext;
    end
  end

  always_ff @(posedge clk or negedge _clr) begin
    if (!_clr) begin
      state <= IDLE;
      _load <= 1'b1;
      en_p  <= 1'b0;
      en_t  <= 1'b0;
      hit   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      _load <= load_nxt;
      en_p  <= en_nxt;
      en_t  <= en_nxt;
      hit   <= hit_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next state plus the output values belonging to that state, so the
  // registered outputs line up with the state register.
  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b1;
    en_nxt    = 1'b0;
    hit_nxt   = 1'b0;
    busy_nxt  = 1'b0;

    case (state)
      IDLE, HOLD: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = COUNT;
      end
      COUNT: begin
        // A new line start pre-empts a carry on the same edge.
        if (start) begin
          state_nxt = LOAD;
        end else if (carry_in) begin
          state_nxt = HOLD;
          hit_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      LOAD: begin
        load_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      COUNT: begin
        en_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        load_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/motion_seq.md
MOTION_SEQ -- requirements
Module: motion_seq

Interface
REQ-001 SHALL have parameter POS_INIT, default 12'hF00, position register value after reset.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 SHALL have port _clr, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, line-start strobe, one clk wide.
REQ-005 SHALL have port vstart, input, 1, frame-start strobe, one clk wide.
REQ-006 SHALL have port vel, input, 4, signed two's-complement velocity (-8..+7).
REQ-007 SHALL have port freeze, input, 1, when high, blocks the position update.
REQ-008 SHALL have port carry_in, input, 1, ripple carry from the last of three cascaded 4-bit sync counters.
REQ-009 SHALL have port _load, output, 1, active-low synchronous load to all three counters.
REQ-010 SHALL have port en_p, output, 1, count-enable P to the counter chain.
REQ-011 SHALL have port en_t, output, 1, count-enable T to the counter chain.
REQ-012 SHALL have port preset, output, 12, load data: [3:0] to the low counter, [11:8] to the high counter.
REQ-013 SHALL have port hit, output, 1, one-cycle pulse when the chain reaches terminal count.
REQ-014 SHALL have port busy, output, 1, high in states LOAD and COUNT.

Function
REQ-015 SHALL implement states IDLE, LOAD, COUNT, HOLD, each encoded as a register.
REQ-016 SHALL set outputs per state: IDLE/HOLD: _load=1, en_p=0, en_t=0; LOAD: _load=0, en_p=0, en_t=0; COUNT: _load=1, en_p=1, en_t=1.
REQ-017 SHALL drive preset combinationally from the internal 12-bit position register pos.
REQ-018 SHALL transition IDLE->LOAD or HOLD->LOAD on the edge where start=1.
REQ-019 SHALL transition LOAD->COUNT unconditionally after exactly one cycle in LOAD.
REQ-020 SHALL transition COUNT->HOLD on the edge where carry_in=1, and assert hit for exactly the following cycle.
REQ-021 SHALL treat start=1 in COUNT as an abort: go to LOAD with no hit, even if carry_in=1 on the same edge.
REQ-022 SHALL ignore start=1 while in LOAD; the state stays LOAD->COUNT.
REQ-023 SHALL ignore carry_in outside COUNT.
REQ-024 SHALL update pos on the edge where vstart=1 and freeze=0: pos <= pos + sign_extend(vel), modulo 4096, with wrap in both directions.
REQ-025 SHALL hold pos when freeze=1 or vstart=0.
REQ-026 SHALL apply the update at the same edge when vstart and start coincide; the LOAD cycle that follows presents the updated pos.
REQ-027 SHALL apply a pos update during COUNT without disturbing the count in progress; the chain already holds the loaded value.
REQ-028 SHALL produce a line latency of 1 LOAD cycle plus (4096 - pos) COUNT cycles from the start edge to the carry edge.

Reset
REQ-029 SHALL, while _clr=0, force state=IDLE, pos=POS_INIT, hit=0, _load=1, en_p=0, en_t=0, busy=0, preset=POS_INIT, asynchronously.
REQ-030 SHALL abandon any count in progress when _clr asserts mid-COUNT, without generating hit.
REQ-031 SHALL treat the first edge after _clr releases as a normal edge; start sampled on that edge SHALL be honoured.

Verification
REQ-032 SHALL cover reset: pulse _clr low mid-COUNT -> same cycle en_p=en_t=0, _load=1, preset=12'hF00, hit never asserts.
REQ-033 SHALL cover a nominal line: pos=12'hFF0, start pulse, counter model driving carry_in -> _load=0 for 1 cycle, en_p/en_t high 16 cycles, hit single pulse, then HOLD.
REQ-034 SHALL cover wrap: pos=12'hFFE, vel=4'sd3, vstart -> pos=12'h001; pos=12'h001, vel=-4'sd2 (4'hE), vstart -> pos=12'hFFF.
REQ-035 SHALL cover freeze: freeze=1, vel=4'sd5, 10 vstart pulses -> pos unchanged at 12'hF00.
REQ-036 SHALL cover abort: start re-asserted at COUNT cycle 5, coincident with carry_in=1 -> no hit, LOAD next cycle, count restarts from preset.
REQ-037 SHALL cover coincident start+vstart: pos=12'hF00, vel=4'sd7 -> the LOAD cycle shows preset=12'hF07, and hit arrives 249 cycles after LOAD.
